// File: rtl/scale_cfg_seq.sv
// scale_cfg_seq: validates a requested source/target geometry, computes 8.8 scale
// factors with a serial restoring divider, and commits everything on a vsync rise.
`timescale 1ns/1ps
`default_nettype none

module scale_cfg_seq #(
  parameter int DEF_S_WIDTH  = 1280,
  parameter int DEF_S_HEIGHT = 720,
  parameter int DEF_T_WIDTH  = 1280,
  parameter int DEF_T_HEIGHT = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_s_width,
  input  logic [10:0] cfg_s_height,
  input  logic [10:0] cfg_t_width,
  input  logic [10:0] cfg_t_height,
  input  logic        vs_i,
  output logic [10:0] s_width,
  output logic [10:0] s_height,
  output logic [10:0] t_width,
  output logic [10:0] t_height,
  output logic [15:0] h_scale_k,
  output logic [15:0] v_scale_k,
  output logic        cfg_update,
  output logic        cfg_err,
  output logic        busy
);

  localparam logic [15:0] DEF_H_K = 16'((DEF_S_WIDTH * 256) / DEF_T_WIDTH);
  localparam logic [15:0] DEF_V_K = 16'((DEF_S_HEIGHT * 256) / DEF_T_HEIGHT);
  localparam logic [4:0]  DIV_LAST = 5'd18;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    DIV_H   = 3'd2,
    DIV_V   = 3'd3,
    WAIT_VS = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        vs_q;
  logic        err_q;
  logic [10:0] p_sw_q, p_sh_q, p_tw_q, p_th_q;
  logic [4:0]  cnt_q;
  logic [18:0] num_q;
  logic [10:0] rem_q;
  logic [15:0] quo_q;
  logic [15:0] hk_p_q, vk_p_q;
  logic [10:0] s_width_q, s_height_q, t_width_q, t_height_q;
  logic [15:0] h_k_q, v_k_q;

  logic        accept;
  logic        vs_rise;
  logic        reject;
  logic [10:0] divisor;
  logic [11:0] trial;
  logic        ge;
  logic [10:0] rem_d;
  logic [15:0] quo_d;

  assign accept  = cfg_valid && (state_q == IDLE);
  assign vs_rise = vs_i && !vs_q;

  // Bounds keep the 19-bit quotient within 16 bits.
  assign reject = (p_sw_q == 11'd0) || (p_sh_q == 11'd0) ||
                  (p_tw_q == 11'd0) || (p_th_q == 11'd0) ||
                  ({8'd0, p_sw_q} >= {p_tw_q, 8'd0}) ||
                  ({8'd0, p_sh_q} >= {p_th_q, 8'd0});

  // Remainder stays below the divisor, so 11 bits of it carry all information.
  assign divisor = (state_q == DIV_V) ? p_th_q : p_tw_q;
  assign trial   = {rem_q, num_q[18]};
  assign ge      = (trial >= {1'b0, divisor});
  assign rem_d   = ge ? (trial[10:0] - divisor) : trial[10:0];
  assign quo_d   = {quo_q[14:0], ge};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK:   state_d = reject ? IDLE : DIV_H;
      DIV_H:   if (cnt_q == DIV_LAST) state_d = DIV_V;
      DIV_V:   if (cnt_q == DIV_LAST) state_d = WAIT_VS;
      WAIT_VS: if (vs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      err_q      <= 1'b0;
      p_sw_q     <= 11'd0;
      p_sh_q     <= 11'd0;
      p_tw_q     <= 11'd0;
      p_th_q     <= 11'd0;
      cnt_q      <= 5'd0;
      num_q      <= 19'd0;
      rem_q      <= 11'd0;
      quo_q      <= 16'd0;
      hk_p_q     <= 16'd0;
      vk_p_q     <= 16'd0;
      s_width_q  <= 11'(DEF_S_WIDTH);
      s_height_q <= 11'(DEF_S_HEIGHT);
      t_width_q  <= 11'(DEF_T_WIDTH);
      t_height_q <= 11'(DEF_T_HEIGHT);
      h_k_q      <= DEF_H_K;
      v_k_q      <= DEF_V_K;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_i;
      err_q   <= (state_q == CHECK) && reject;
      if (accept) begin
        p_sw_q <= cfg_s_width;
        p_sh_q <= cfg_s_height;
        p_tw_q <= cfg_t_width;
        p_th_q <= cfg_t_height;
      end
      case (state_q)
        CHECK: begin
          num_q <= {p_sw_q, 8'd0};
          rem_q <= 11'd0;
          quo_q <= 16'd0;
          cnt_q <= 5'd0;
        end
        DIV_H, DIV_V: begin
          num_q <= {num_q[17:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == DIV_LAST) begin
            if (state_q == DIV_H) hk_p_q <= quo_d;
            else                  vk_p_q <= quo_d;
            num_q <= {p_sh_q, 8'd0};
            rem_q <= 11'd0;
            quo_q <= 16'd0;
            cnt_q <= 5'd0;
          end
        end
        WAIT_VS: begin
          if (vs_rise) begin
            s_width_q  <= p_sw_q;
            s_height_q <= p_sh_q;
            t_width_q  <= p_tw_q;
            t_height_q <= p_th_q;
            h_k_q      <= hk_p_q;
            v_k_q      <= vk_p_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cfg_update = (state_q == COMMIT);
  assign cfg_err    = err_q;
  assign s_width    = s_width_q;
  assign s_height   = s_height_q;
  assign t_width    = t_width_q;
  assign t_height   = t_height_q;
  assign h_scale_k  = h_k_q;
  assign v_scale_k  = v_k_q;

endmodule

`default_nettype wire

// File: doc/scale_cfg_seq.md
# scale_cfg_seq

Frame-synchronous configuration sequencer for the scaler datapath. It accepts a requested source/target geometry over a valid/ready handshake and validates it. It computes the horizontal and vertical 8.8 fixed-point scale factors with a serial divider. It then commits the whole parameter set atomically on the next rising edge of frame vsync. It sits between the control logic (keys/UART mode selection) and the scaler/frame-buffer blocks, so those blocks never see a geometry change mid-frame.

## Interface
Parameters:
- DEF_S_WIDTH, 1280, source width after reset
- DEF_S_HEIGHT, 720, source height after reset
- DEF_T_WIDTH, 1280, target width after reset
- DEF_T_HEIGHT, 720, target height after reset

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  request holds a new geometry
- cfg_ready  out  1  block accepts a request; high only in IDLE
- cfg_s_width, cfg_s_height, cfg_t_width, cfg_t_height  in  11 each  requested geometry; sampled on accept
- vs_i  in  1  frame vsync, active-high
- s_width, s_height, t_width, t_height  out  11 each  committed geometry
- h_scale_k, v_scale_k  out  16 each  committed factors, 8.8 fixed point
- cfg_update  out  1  one-cycle pulse; committed outputs changed this cycle
- cfg_err  out  1  one-cycle pulse; request rejected
- busy  out  1  high in every state except IDLE

## Operation
- Accept occurs when cfg_valid & cfg_ready. The four inputs are latched into a pending set.
- States and transitions:
  - IDLE: cfg_ready=1; accept -> CHECK.
  - CHECK: one cycle; reject -> IDLE with cfg_err; pass -> DIV_H.
  - DIV_H: 19 cycles; -> DIV_V.
  - DIV_V: 19 cycles; -> WAIT_VS.
  - WAIT_VS: on vs rising edge -> COMMIT.
  - COMMIT: one cycle; -> IDLE.
- Reject rule: any t field == 0, or any s field == 0, or s_width >= 256*t_width, or s_height >= 256*t_height. These conditions guarantee the quotient fits in 16 bits.
- Division:
  - h_k = floor((s_width << 8) / t_width), with a 19-bit numerator. v_k is computed the same way from the heights.
  - Restoring divider, one quotient bit per cycle, MSB first. The 12-bit remainder is compared against the 11-bit divisor.
  - The quotient is 19 bits wide; the low 16 bits are taken, and the upper 3 bits are zero by the reject rule.
- Vsync edge: vs_d is registered every cycle, including during reset, when it clears to 0. rise = vs_i & ~vs_d.
  - Only a rise seen while in WAIT_VS counts.
  - A rise during DIV_H or DIV_V is ignored, and the commit waits for the following frame.
- COMMIT: all six outputs load from the pending set and the divider results on the same clock edge. cfg_update is high for exactly that cycle.
- Outputs change only in COMMIT. A rejected request, or a request still pending, leaves them untouched.
- cfg_valid while busy is ignored. The requester must hold cfg_valid until it sees cfg_ready.

## Timing
- Reset values:
  - state IDLE, cfg_ready=1, busy=0, cfg_update=0, cfg_err=0.
  - Geometry outputs = DEF_*.
  - h_scale_k = (DEF_S_WIDTH<<8)/DEF_T_WIDTH and v_scale_k = (DEF_S_HEIGHT<<8)/DEF_T_HEIGHT, computed at elaboration; both 16'h0100 with the defaults.
- Accept at edge 0:
  - CHECK during cycle 1.
  - DIV_H during cycles 2–20.
  - DIV_V during cycles 21–39.
  - WAIT_VS from cycle 40.
- Commit latency is the cycle after the first vs rise registered from cycle 40 on: minimum 41 cycles after accept.
- cfg_err is asserted in the cycle after CHECK, as the block returns to IDLE with cfg_ready=1. The earliest following accept is one cycle later.
- If vs_i is already high on entry to WAIT_VS, there is no commit until vs_i falls and rises again.
- Reset mid-operation (any state):
  - Returns immediately to reset values.
  - The pending set is discarded.
  - No cfg_update or cfg_err pulse is produced.

## Test plan
1. Reset release with vs_i toggling and no requests -> outputs stay 1280/720/1280/720, both k = 0x0100, cfg_update never pulses.
2. Request 1280x720 -> 640x720 accepted, vs rise at cycle 60 -> cfg_ready low for the whole interval. In the commit cycle cfg_update=1, h_scale_k=0x0200, v_scale_k=0x0100, t_width=640; outputs are unchanged before that cycle.
3. Request 1280x720 -> 1920x1080 -> h_k=0x00AA and v_k=0x00AA (floor of 170.67). A vs rise at cycle 25 is ignored; the commit occurs on the next rise after cycle 40.
4. Request t_width=0, then a separate request s_width=512/t_width=2 -> cfg_err pulses once for each, outputs unchanged, cfg_ready returns high within 2 cycles.
5. Assert rst during DIV_V, then issue a new 1280 -> 1280 request -> outputs hold defaults, the first request never commits, and the second commits with k = 0x0100.
6. Pulse cfg_valid while busy with a different geometry -> not accepted; the first request's values are the ones committed.
